// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
// Registered N-to-2**N decoder with a valid/ready output slot and an
// auto-scan mode that walks a one-hot bit across the output word.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   en         : global enable; freezes scanning and accepts when low
//   mode       : 00 one-hot, 01 thermometer, 10 auto-scan, 11 reserved (d=0)
//   sel        : decode index (also the scan start index)
//   in_valid   : sel/mode valid
//   in_ready   : block accepts sel/mode this cycle
//   d          : registered decoded word
//   out_valid  : d holds an unconsumed result
//   out_ready  : consumer takes d
//   scan_wrap  : one-cycle pulse after the scan index steps from M-1 to 0
// ---------------------------------------------------------------------------
module decoder_seq #(
   parameter  int N = 3,
   localparam int M = 2**N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [1:0]   mode,
   input  logic [N-1:0] sel,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [M-1:0] d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         scan_wrap
);

   localparam logic [1:0]   MODE_ONEHOT = 2'b00;
   localparam logic [1:0]   MODE_THERMO = 2'b01;
   localparam logic [1:0]   MODE_SCAN   = 2'b10;
   localparam logic [N-1:0] IDX_MAX     = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t         state_q,     state_d;
   logic [N-1:0]   scan_idx_q,  scan_idx_d;
   logic [M-1:0]   d_q,         d_d;
   logic           out_valid_q, out_valid_d;
   logic           scan_wrap_q, scan_wrap_d;

   logic           accept;
   logic           pop;
   logic           scan_mode;
   logic           slot_free;
   logic [N-1:0]   next_idx;

   function automatic logic [M-1:0] onehot(input logic [N-1:0] idx);
      logic [M-1:0] w;
      w      = '0;
      w[idx] = 1'b1;
      return w;
   endfunction

   function automatic logic [M-1:0] thermo(input logic [N-1:0] idx);
      logic [M-1:0] w;
      for (int i = 0; i < M; i++) begin
         w[i] = (i <= int'(idx));
      end
      return w;
   endfunction

   // Mode 10 never reaches here (in_ready is low); 11 decodes to all zeros.
   function automatic logic [M-1:0] decode(input logic [1:0]   md,
                                           input logic [N-1:0] idx);
      logic [M-1:0] w;
      case (md)
         MODE_ONEHOT: w = onehot(idx);
         MODE_THERMO: w = thermo(idx);
         default:     w = '0;
      endcase
      return w;
   endfunction

   assign scan_mode = (mode == MODE_SCAN);
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = rst_n && en && !scan_mode && slot_free;
   assign accept    = in_valid && in_ready;
   // A transfer out completes even with en low, but never during reset.
   assign pop       = rst_n && out_valid_q && out_ready;
   assign next_idx  = scan_idx_q + 1'b1;

   // Output slot first, then the scan FSM. The two never load d in the same
   // cycle because in_ready is low whenever mode selects auto-scan.
   always_comb begin
      state_d     = state_q;
      scan_idx_d  = scan_idx_q;
      d_d         = d_q;
      out_valid_d = out_valid_q;
      scan_wrap_d = 1'b0;

      if (pop) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         d_d         = decode(mode, sel);
         out_valid_d = 1'b1;
      end

      if (en) begin
         if (state_q == ST_IDLE) begin
            if (scan_mode) begin
               state_d     = ST_SCAN;
               scan_idx_d  = sel;
               d_d         = onehot(sel);
               out_valid_d = 1'b1;
            end
         end else begin
            if (!scan_mode) begin
               state_d = ST_IDLE;
            end else if (slot_free) begin
               scan_idx_d  = next_idx;
               d_d         = onehot(next_idx);
               out_valid_d = 1'b1;
               scan_wrap_d = (scan_idx_q == IDX_MAX);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         scan_idx_q  <= '0;
         d_q         <= '0;
         out_valid_q <= 1'b0;
         scan_wrap_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_idx_q  <= scan_idx_d;
         d_q         <= d_d;
         out_valid_q <= out_valid_d;
         scan_wrap_q <= scan_wrap_d;
      end
   end

   assign d         = d_q;
   assign out_valid = out_valid_q;
   assign scan_wrap = scan_wrap_q;

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL have parameter N, default 3, meaning select width.
REQ-002 SHALL have derived parameter M = 2**N, default 8, meaning output width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port en, input, 1, global enable.
REQ-006 SHALL have port mode, input, 2, meaning 00 one-hot, 01 thermometer, 10 auto-scan, 11 reserved.
REQ-007 SHALL have port sel, input, N, decode index.
REQ-008 SHALL have port in_valid, input, 1, sel/mode valid.
REQ-009 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-010 SHALL have port d, output, M, registered decoded word.
REQ-011 SHALL have port out_valid, output, 1, d holds an unconsumed result.
REQ-012 SHALL have port out_ready, input, 1, consumer takes d.
REQ-013 SHALL have port scan_wrap, output, 1, one-cycle pulse on scan index wrap.

Function
REQ-014 Transfer in SHALL occur when in_valid and in_ready are both high; transfer out SHALL occur when out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal en and (mode != 10) and (not out_valid or out_ready), combinationally.
REQ-016 Latency SHALL be 1 cycle: an input accepted at edge k SHALL appear on d with out_valid=1 after edge k.
REQ-017 Mode 00 SHALL set d[i]=1 only for i=sel; all other bits 0.
REQ-018 Mode 01 SHALL set d[i]=1 for all i<=sel and 0 for all i>sel; sel=M-1 gives all ones.
REQ-019 Mode 11 SHALL be accepted like any mode and SHALL produce d=0 with out_valid=1.
REQ-020 With out_valid=1, out_ready=0 and no accept, d and out_valid SHALL hold unchanged.
REQ-021 If a transfer out occurs with no accept in the same cycle, out_valid SHALL clear next cycle and d SHALL hold its last value.
REQ-022 Simultaneous transfer out and accept SHALL load the new result with out_valid staying 1, with no bubble.
REQ-023 Auto-scan (mode=10) SHALL use an internal N-bit index scan_idx with states IDLE and SCAN.
REQ-024 IDLE->SCAN SHALL occur on the first cycle with en=1 and mode=10; scan_idx SHALL load sel, and d SHALL become onehot(sel) with out_valid=1.
REQ-025 In SCAN, on each cycle with en=1 and (out_valid=0 or out_ready=1), scan_idx SHALL increment mod M and d SHALL become onehot(new scan_idx).
REQ-026 scan_wrap SHALL pulse high for exactly the cycle following a step from M-1 to 0; it SHALL be 0 otherwise.
REQ-027 In SCAN, when out_valid=1 and out_ready=0, scan_idx and d SHALL hold and no step SHALL occur.
REQ-028 SCAN->IDLE SHALL occur when mode!=10; d and out_valid SHALL hold, and the next accept follows REQ-014..REQ-022.
REQ-029 en=0 SHALL freeze scan_idx, the state machine and all accepts; transfer out SHALL still clear out_valid.
REQ-030 sel and mode SHALL be sampled only on accept or on IDLE->SCAN entry; changes at other times SHALL have no effect.

Reset
REQ-031 When rst_n=0 at a clock edge: d=0, out_valid=0, scan_wrap=0, scan_idx=0, state=IDLE.
REQ-032 Reset SHALL override every other input, including mid-scan and with out_valid=1; no transfer SHALL complete in a reset cycle.
REQ-033 in_ready SHALL be 0 while rst_n=0 and SHALL follow REQ-015 from the first cycle after release.

Verification (N=3)
REQ-034 Scenario: mode=00, sel=5, in_valid=1, out_ready=1 -> next cycle d=8'b0010_0000, out_valid=1.
REQ-035 Scenario: mode=01, sel=3 -> d=8'b0000_1111; then sel=7 -> d=8'hFF.
REQ-036 Scenario: back-to-back accepts sel=0,1,2 with out_ready=0 on the second result -> in_ready=0, d=8'h02 held until out_ready=1, then d=8'h04 with no bubble.
REQ-037 Scenario: mode=10, sel=6, out_ready=1 -> d sequence 8'h40, 8'h80, 8'h01; scan_wrap=1 only with d=8'h01.
REQ-038 Scenario: in scan with d=8'h08, out_ready=0 for 3 cycles -> d stays 8'h08, scan_wrap=0; resumes with 8'h10.
REQ-039 Scenario: rst_n=0 for one edge mid-scan with d=8'h20 -> next cycle d=0, out_valid=0, scan_wrap=0, state=IDLE.
